// File: rtl/da_lut_arb_pkg.sv
// Shared definitions for the distributed-arithmetic LUT blocks: FSM state
// encodings, active-low SRAM enable levels and default LUT geometry.
package da_lut_arb_pkg;

  // Default LUT geometry: 2^4 precomputed partial sums of 16 bits each.
  localparam int DA_ADDR_W = 4;
  localparam int DA_DATA_W = 16;

  // SRAM chip/write enables are active-low.
  localparam logic EN_ON  = 1'b0;
  localparam logic EN_OFF = 1'b1;

  // Loader / arbiter states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } da_state_t;

endpackage

// File: rtl/da_lut_arb.sv
// LUT loader and read arbiter for a DA filter engine. A host streams the
// precomputed partial sums into an external single-port SRAM; once every
// entry is written, the DA engine may read one word per cycle. A reload
// (cload) always wins over engine reads, but reads already issued still
// return their data.
module da_lut_arb
  import da_lut_arb_pkg::*;
#(
  parameter int ADDR_W = DA_ADDR_W,
  parameter int DATA_W = DA_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  // host loader side
  input  logic              cload,
  input  logic              lut_valid,
  input  logic [DATA_W-1:0] lut_data,
  output logic              lut_ready,
  // DA engine side
  input  logic              eng_req,
  input  logic [ADDR_W-1:0] eng_addr,
  output logic              eng_gnt,
  output logic              eng_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  // status
  output logic              lut_loaded,
  output logic              load_err,
  // external SRAM macro
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  da_state_t         state_reg;
  logic [ADDR_W-1:0] cnt_reg;
  logic              lut_loaded_reg;
  logic              load_err_reg;
  logic              rd_issue_reg;
  logic              rvalid_reg;
  logic              sram_cen_reg;
  logic              sram_wen_reg;
  logic [ADDR_W-1:0] sram_a_reg;
  logic [DATA_W-1:0] sram_d_reg;

  logic beat_acc;
  logic rd_gnt;

  // The loader only takes beats while the host holds cload in LOAD; engine
  // reads are only granted in READY and lose to a pending reload.
  assign lut_ready = (state_reg == ST_LOAD) & cload;
  assign beat_acc  = lut_valid & lut_ready;
  assign rd_gnt    = eng_req & (state_reg == ST_READY) & ~cload;

  // Load sequencing: address counter, loaded flag and abort pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      lut_loaded_reg <= 1'b0;
      load_err_reg   <= 1'b0;
    end else begin
      load_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cload) begin
            state_reg      <= ST_LOAD;
            cnt_reg        <= '0;
            lut_loaded_reg <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!cload) begin
            // Host gave up before the table was complete.
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            lut_loaded_reg <= 1'b0;
            load_err_reg   <= 1'b1;
          end else if (beat_acc) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_ADDR) begin
              state_reg      <= ST_READY;
              lut_loaded_reg <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (cload) begin
            state_reg      <= ST_LOAD;
            cnt_reg        <= '0;
            lut_loaded_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // SRAM port: one registered access per cycle. Writes only happen in LOAD
  // and grants only in READY, so the two can never collide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sram_cen_reg <= EN_OFF;
      sram_wen_reg <= EN_OFF;
      sram_a_reg   <= '0;
      sram_d_reg   <= '0;
    end else if (beat_acc) begin
      sram_cen_reg <= EN_ON;
      sram_wen_reg <= EN_ON;
      sram_a_reg   <= cnt_reg;
      sram_d_reg   <= lut_data;
    end else if (rd_gnt) begin
      sram_cen_reg <= EN_ON;
      sram_wen_reg <= EN_OFF;
      sram_a_reg   <= eng_addr;
    end else begin
      sram_cen_reg <= EN_OFF;
      sram_wen_reg <= EN_OFF;
    end
  end

  // Read return pipeline: access cycle after the grant, data one cycle later.
  // Independent of the FSM so a reload never drops an issued read.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_issue_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
    end else begin
      rd_issue_reg <= rd_gnt;
      rvalid_reg   <= rd_issue_reg;
    end
  end

  assign eng_gnt    = rd_gnt;
  assign eng_rvalid = rvalid_reg;
  assign eng_rdata  = sram_q;
  assign lut_loaded = lut_loaded_reg;
  assign load_err   = load_err_reg;
  assign sram_cen   = sram_cen_reg;
  assign sram_wen   = sram_wen_reg;
  assign sram_a     = sram_a_reg;
  assign sram_d     = sram_d_reg;

endmodule

// File: tb/tb_da_lut_arb.sv
// Directed + randomized bench for da_lut_arb with a behavioural SRAM and a
// reference LUT image kept by the bench.
module tb_da_lut_arb;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b1;
  logic          cload = 1'b0;
  logic          lut_valid = 1'b0;
  logic [DW-1:0] lut_data = '0;
  logic          lut_ready;
  logic          eng_req = 1'b0;
  logic [AW-1:0] eng_addr = '0;
  logic          eng_gnt;
  logic          eng_rvalid;
  logic [DW-1:0] eng_rdata;
  logic          lut_loaded;
  logic          load_err;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural SRAM contents, write log, and expected LUT image.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ref_lut [DEPTH];
  int            wlog_a [$];

  typedef struct {
    int due;
    int addr;
  } rd_t;
  rd_t rdq [$];

  da_lut_arb #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cload      (cload),
    .lut_valid  (lut_valid),
    .lut_data   (lut_data),
    .lut_ready  (lut_ready),
    .eng_req    (eng_req),
    .eng_addr   (eng_addr),
    .eng_gnt    (eng_gnt),
    .eng_rvalid (eng_rvalid),
    .eng_rdata  (eng_rdata),
    .lut_loaded (lut_loaded),
    .load_err   (load_err),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAM model: write on a write access, registered read data.
  always @(posedge clk) begin
    if (resetn && !sram_cen) begin
      if (!sram_wen) begin
        mem[sram_a] <= sram_d;
        wlog_a.push_back(int'(sram_a));
      end else begin
        sram_q <= mem[sram_a];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; a read granted in cycle c must return in cycle c+2.
  task automatic step();
    @(posedge clk);
    #1;
    if (rdq.size() > 0 && rdq[0].due == cyc) begin
      chk("rvalid", 32'(eng_rvalid), 32'(1));
      chk("rdata", 32'(eng_rdata), 32'(ref_lut[rdq[0].addr]));
      $display("read addr=%0d data=%h", rdq[0].addr, eng_rdata);
      void'(rdq.pop_front());
    end else begin
      chk("rvalid_idle", 32'(eng_rvalid), 32'(0));
    end
  endtask

  task automatic read_issue(input int a, input bit exp_gnt);
    eng_req  = 1'b1;
    eng_addr = AW'(a);
    #1;
    chk("eng_gnt", 32'(eng_gnt), 32'(exp_gnt));
    if (exp_gnt) rdq.push_back('{cyc + 2, a});
  endtask

  // Stream nbeats beats; leaves cload high and lut_valid low on return.
  task automatic run_load(input int nbeats, input bit throttle, input bit incdata);
    int acc;
    int iter;
    bit sent;
    logic [DW-1:0] beat;
    acc  = 0;
    iter = 0;
    cload     = 1'b1;
    lut_valid = 1'b0;
    step();
    chk("load_entry_loaded", 32'(lut_loaded), 32'(0));
    while (acc < nbeats && iter < 100) begin
      sent = throttle ? (iter[0] == 1'b0) : 1'b1;
      beat = incdata ? DW'(acc) : DW'($urandom);
      lut_valid = sent;
      lut_data  = beat;
      #1;
      chk("lut_ready", 32'(lut_ready), 32'(1));
      step();
      if (sent) begin
        ref_lut[acc] = beat;
        chk("wr_cen", 32'(sram_cen), 32'(0));
        chk("wr_wen", 32'(sram_wen), 32'(0));
        chk("wr_a", 32'(sram_a), 32'(acc));
        chk("wr_d", 32'(sram_d), 32'(beat));
        acc++;
      end else begin
        chk("gap_cen", 32'(sram_cen), 32'(1));
      end
      iter++;
    end
    lut_valid = 1'b0;
    chk("load_budget", 32'(acc), 32'(nbeats));
  endtask

  task automatic full_load(input bit throttle, input bit incdata, input string name);
    int w0;
    w0 = wlog_a.size();
    run_load(DEPTH, throttle, incdata);
    chk("loaded_after_last", 32'(lut_loaded), 32'(1));
    cload = 1'b0;
    step();
    chk("write_count", 32'(wlog_a.size() - w0), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) chk("write_addr_order", 32'(wlog_a[w0 + k]), 32'(k));
    chk("loaded_hold", 32'(lut_loaded), 32'(1));
    $display("load %s: %0d writes, lut_loaded=%0d", name, wlog_a.size() - w0, lut_loaded);
  endtask

  task automatic random_reads(input int n);
    int a;
    bit g;
    for (int i = 0; i < n; i++) begin
      g = ($urandom_range(0, 3) != 0);
      a = $urandom_range(0, DEPTH - 1);
      if (g) read_issue(a, 1'b1);
      else eng_req = 1'b0;
      step();
      if (g) begin
        chk("rd_cen", 32'(sram_cen), 32'(0));
        chk("rd_wen", 32'(sram_wen), 32'(1));
        chk("rd_a", 32'(sram_a), 32'(a));
      end else begin
        chk("rd_idle_cen", 32'(sram_cen), 32'(1));
      end
    end
    eng_req = 1'b0;
    step();
    step();
    chk("reads_drained", 32'(rdq.size()), 32'(0));
  endtask

  initial begin
    int rd_list [3];
    rd_list[0] = 5;
    rd_list[1] = 6;
    rd_list[2] = 15;

    // Asynchronous reset before any clock edge.
    #1 resetn = 1'b0;
    #1;
    chk("rst_cen", 32'(sram_cen), 32'(1));
    chk("rst_wen", 32'(sram_wen), 32'(1));
    chk("rst_a", 32'(sram_a), 32'(0));
    chk("rst_d", 32'(sram_d), 32'(0));
    chk("rst_loaded", 32'(lut_loaded), 32'(0));
    chk("rst_load_err", 32'(load_err), 32'(0));
    chk("rst_rvalid", 32'(eng_rvalid), 32'(0));
    chk("rst_lut_ready", 32'(lut_ready), 32'(0));
    step();
    step();
    @(negedge clk) resetn = 1'b1;
    step();
    chk("post_rst_cen", 32'(sram_cen), 32'(1));
    eng_req = 1'b1;
    #1;
    chk("idle_gnt", 32'(eng_gnt), 32'(0));
    eng_req = 1'b0;

    // Full load of 0x0000..0x000F, then reads of 5, 6, 15 back-to-back.
    full_load(1'b0, 1'b1, "incrementing");
    for (int i = 0; i < 3; i++) begin
      read_issue(rd_list[i], 1'b1);
      step();
      chk("rd_cen", 32'(sram_cen), 32'(0));
      chk("rd_wen", 32'(sram_wen), 32'(1));
      chk("rd_a", 32'(sram_a), 32'(rd_list[i]));
    end
    eng_req = 1'b0;
    step();
    step();
    chk("reads_drained", 32'(rdq.size()), 32'(0));
    chk("lut_word_f", 32'(mem[15]), 32'(16'h000F));

    // Throttled reload with random data, then random engine traffic.
    full_load(1'b1, 1'b0, "throttled");
    random_reads(20);

    // Aborted load after 7 beats.
    run_load(7, 1'b0, 1'b0);
    cload    = 1'b0;
    eng_req  = 1'b1;
    eng_addr = 4'd2;
    #1;
    chk("abort_lut_ready", 32'(lut_ready), 32'(0));
    step();
    chk("abort_err_pulse", 32'(load_err), 32'(1));
    chk("abort_loaded", 32'(lut_loaded), 32'(0));
    chk("abort_gnt", 32'(eng_gnt), 32'(0));
    step();
    chk("abort_err_clear", 32'(load_err), 32'(0));
    chk("abort_gnt_idle", 32'(eng_gnt), 32'(0));
    chk("abort_cen", 32'(sram_cen), 32'(1));
    eng_req = 1'b0;
    $display("load aborted after 7 beats: lut_loaded=%0d", lut_loaded);

    // Reload race: in-flight read survives, simultaneous request is refused.
    full_load(1'b0, 1'b0, "random");
    read_issue(3, 1'b1);
    step();
    chk("race_rd_a", 32'(sram_a), 32'(3));
    cload = 1'b1;
    read_issue(7, 1'b0);
    chk("race_lut_ready_ready", 32'(lut_ready), 32'(0));
    step();
    chk("race_loaded", 32'(lut_loaded), 32'(0));
    chk("race_in_load", 32'(lut_ready), 32'(1));
    chk("race_no_access", 32'(sram_cen), 32'(1));
    chk("race_drained", 32'(rdq.size()), 32'(0));
    eng_req = 1'b0;
    $display("reload race: grant refused, in-flight read delivered");
    full_load(1'b0, 1'b0, "after-race");

    // Asynchronous reset in the middle of a load (after beat 9).
    run_load(9, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_cen", 32'(sram_cen), 32'(1));
    chk("mid_rst_wen", 32'(sram_wen), 32'(1));
    chk("mid_rst_a", 32'(sram_a), 32'(0));
    chk("mid_rst_d", 32'(sram_d), 32'(0));
    chk("mid_rst_loaded", 32'(lut_loaded), 32'(0));
    chk("mid_rst_lut_ready", 32'(lut_ready), 32'(0));
    cload = 1'b0;
    @(negedge clk) resetn = 1'b1;
    step();
    chk("mid_rst_release_cen", 32'(sram_cen), 32'(1));
    $display("reset during load at beat 9");
    full_load(1'b0, 1'b0, "post-reset");
    random_reads(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/da_lut_arb.md
DA_LUT_ARB -- requirements
Module: da_lut_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, LUT address width (2^ADDR_W entries of precomputed DA partial sums).
REQ-002 SHALL have parameter DATA_W, default 16, LUT word width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port cload  in  1  load-mode request; high for the whole load.
REQ-006 SHALL have port lut_valid  in  1  lut_data beat valid.
REQ-007 SHALL have port lut_data  in  DATA_W  precomputed LUT word, streamed in address order from 0.
REQ-008 SHALL have port lut_ready  out  1  loader can accept a beat.
REQ-009 SHALL have port eng_req  in  1  DA engine read request.
REQ-010 SHALL have port eng_addr  in  ADDR_W  DA engine read address (bit-slice of the sample shift register).
REQ-011 SHALL have port eng_gnt  out  1  read request accepted this cycle.
REQ-012 SHALL have port eng_rvalid  out  1  eng_rdata holds read data.
REQ-013 SHALL have port eng_rdata  out  DATA_W  read data, equal to sram_q.
REQ-014 SHALL have port lut_loaded  out  1  all 2^ADDR_W entries written since the last load start.
REQ-015 SHALL have port load_err  out  1  one-cycle pulse on an aborted load.
REQ-016 SHALL have ports sram_cen, sram_wen  out  1 each  single-port SRAM chip and write enables, active-low.
REQ-017 SHALL have port sram_a  out  ADDR_W  SRAM address.
REQ-018 SHALL have port sram_d  out  DATA_W  SRAM write data.
REQ-019 SHALL have port sram_q  in  DATA_W  SRAM read data, valid one cycle after the read access cycle.

Function
REQ-020 SHALL implement the FSM IDLE, LOAD, READY.
REQ-021 SHALL move IDLE->LOAD when cload=1; the load address counter is cleared to 0 and lut_loaded cleared.
REQ-022 SHALL drive lut_ready=1 only in LOAD with cload=1 (combinational from state and cload).
REQ-023 SHALL accept a beat on an edge with lut_valid&lut_ready; during the next cycle it drives sram_cen=0, sram_wen=0, sram_a=counter, sram_d=beat; the counter then increments.
REQ-024 SHALL leave sram_cen=1 and sram_wen=1 in every cycle that follows no accepted beat and no grant.
REQ-025 SHALL, on acceptance of the beat at address 2^ADDR_W-1, go to READY and set lut_loaded=1 on the same edge.
REQ-026 SHALL, if cload falls in LOAD before the last beat, return to IDLE, keep lut_loaded=0, and pulse load_err for one cycle.
REQ-027 SHALL drive eng_gnt = eng_req & (state==READY) & ~cload; requests outside READY are ignored, not queued.
REQ-028 SHALL, for a grant at edge k, drive sram_cen=0, sram_wen=1, sram_a=eng_addr(k) in cycle k+1, and pulse eng_rvalid in cycle k+2; back-to-back grants every cycle are supported.
REQ-029 SHALL, on cload=1 in READY, go to LOAD (reload), clearing lut_loaded and the counter; cload wins over a simultaneous eng_req.
REQ-030 SHALL still complete an SRAM read already issued when a reload starts, and SHALL deliver its eng_rvalid.
REQ-031 SHALL make SRAM write and read accesses mutually exclusive in any cycle.
REQ-032 SHALL register every SRAM control output; no combinational path from inputs to sram_* exists.

Reset
REQ-033 SHALL, on resetn=0, asynchronously force: state IDLE, counter 0, lut_loaded=0, load_err=0, eng_rvalid=0, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
REQ-034 SHALL treat reset mid-load or mid-read as an abort; no SRAM access occurs in the first cycle after release.

Structure
REQ-035 SHALL place the FSM state encodings, the active-low enable constants (ON=0, OFF=1) and default widths in the shared DA package.
REQ-036 SHALL remain a single module with no sub-modules; the SRAM macro is instantiated outside it.

Verification
REQ-037 SHALL verify full load: cload=1 with 16 beats 0x0000..0x000F back-to-back -> 16 writes at A=0..15 one cycle after each beat, and lut_loaded=1 after the 16th.
REQ-038 SHALL verify a throttled load: lut_valid toggled every other cycle -> exactly 16 writes and no duplicate addresses.
REQ-039 SHALL verify an aborted load: cload drops after 7 beats -> IDLE, load_err pulses once, lut_loaded=0, and eng_req stays ungranted.
REQ-040 SHALL verify reads: after load, eng_addr 5,6,15 on consecutive cycles -> eng_rvalid for three cycles starting 2 cycles later, with data 0x0005, 0x0006, 0x000F.
REQ-041 SHALL verify the reload race: eng_req and cload both high in READY -> eng_gnt=0, LOAD entered, and an in-flight read's eng_rvalid is still delivered.
REQ-042 SHALL verify asynchronous reset mid-load at beat 9 -> outputs reach their reset values immediately, and a subsequent full load succeeds.
